// File: rtl/i2c_result_target.sv
// I2C target exposing an 8-byte image-processing result, a host-writable mode
// register and a constant ID byte. The bus is oversampled on clk; SDA is open drain.
module i2c_result_target #(
  parameter logic [6:0] DEV_ADDR = 7'h55,
  parameter logic [7:0] ID_BYTE  = 8'hEB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        res_valid,
  input  logic [63:0] res_data,
  output logic [7:0]  mode_out,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  logic        scl_m_q, scl_s_q, scl_p_q;
  logic        sda_m_q, sda_s_q, sda_p_q;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  tx_q, tx_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  mode_q, mode_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] rbuf_q, rbuf_d;

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] sr_next, rd_byte;
  logic [3:0] ptr_inc;

  assign scl_rise = scl_s_q & ~scl_p_q;
  assign scl_fall = ~scl_s_q & scl_p_q;
  assign start_c  = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_c   = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
  assign sr_next  = {sr_q[6:0], sda_s_q};
  assign ptr_inc  = (ptr_q == 4'd9) ? 4'd0 : ptr_q + 4'd1;

  // Byte 0 sits in the top of the buffer, so byte n starts at bit 8*(7-n).
  always_comb begin
    rd_byte = 8'h00;
    if (ptr_q < 4'd8)       rd_byte = rbuf_q[{~ptr_q[2:0], 3'b000} +: 8];
    else if (ptr_q == 4'd8) rd_byte = mode_q;
    else if (ptr_q == 4'd9) rd_byte = ID_BYTE;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    rw_d     = rw_q;
    phase_d  = phase_q;
    ptr_d    = ptr_q;
    tx_d     = tx_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    mode_d   = mode_q;
    rbuf_d   = rbuf_q;
    shadow_d = res_valid ? res_data : shadow_q;
    if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR: if (scl_rise) begin
          sr_d  = sr_next;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            phase_d = 1'b0;
            case (state_q)
              ADDR:    state_d = ADDR_ACK;
              PTR:     state_d = PTR_ACK;
              default: state_d = WR_ACK;
            endcase
          end
        end
        // ACK states: first SCL fall drives the ACK, second fall releases it.
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            if (sr_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
              busy_d   = 1'b1;
              rw_d     = sr_q[0];
              if (sr_q[0]) rbuf_d = res_valid ? res_data : shadow_q;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else begin
            phase_d = 1'b0;
            if (rw_q) begin
              state_d  = RD;
              tx_d     = {rd_byte[6:0], 1'b0};
              sda_oe_d = ~rd_byte[7];
              cnt_d    = 4'd1;
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
            end
          end
        end
        PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
            if (state_q == PTR_ACK) begin
              ptr_d = (sr_q > 8'h09) ? 4'd0 : sr_q[3:0];
            end else begin
              if (ptr_q == 4'd8) mode_d = sr_q;
              ptr_d = ptr_inc;
            end
          end else begin
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = WR;
          end
        end
        RD: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
            phase_d  = 1'b0;
            ptr_d    = ptr_inc;
          end else begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s_q) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d  = 1'b0;
            state_d  = RD;
            tx_d     = {rd_byte[6:0], 1'b0};
            sda_oe_d = ~rd_byte[7];
            cnt_d    = 4'd1;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_m_q, scl_s_q, scl_p_q} <= 3'b111;
      {sda_m_q, sda_s_q, sda_p_q} <= 3'b111;
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sr_q     <= 8'h00;
      rw_q     <= 1'b0;
      phase_q  <= 1'b0;
      ptr_q    <= 4'd0;
      tx_q     <= 8'h00;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      mode_q   <= 8'h00;
      shadow_q <= 64'h0;
      rbuf_q   <= 64'h0;
    end else begin
      scl_m_q  <= scl_in;
      scl_s_q  <= scl_m_q;
      scl_p_q  <= scl_s_q;
      sda_m_q  <= sda_in;
      sda_s_q  <= sda_m_q;
      sda_p_q  <= sda_s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      rw_q     <= rw_d;
      phase_q  <= phase_d;
      ptr_q    <= ptr_d;
      tx_q     <= tx_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      rbuf_q   <= rbuf_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign mode_out = mode_q;

endmodule
